// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port, 1-cycle-latency word memory
// between the instruction-fetch port (0, read-only) and the load/store port (1).
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 448
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_done,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [3:0]        p1_wmask,
    input  logic [31:0]       p1_wdata,
    output logic              p1_done,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_en,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              err_pend_q, err_pend_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              p0_err_q, p0_err_d;
    logic              p1_err_q, p1_err_d;

    logic              elig0, elig1, grant, win;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_wmask;
    logic [31:0]       sel_wdata;
    logic              in_range;

    // The owner being served in WAIT has had its request consumed.
    always_comb begin
        elig0     = p0_req && !(state_q == WAIT && owner_q == 1'b0);
        elig1     = p1_req && !(state_q == WAIT && owner_q == 1'b1);
        grant     = (state_q == IDLE || state_q == WAIT) && (elig0 || elig1);
        win       = (elig0 && elig1) ? ~last_q : elig1;
        sel_addr  = win ? p1_addr : p0_addr;
        sel_wmask = win ? p1_wmask : 4'b0000;
        sel_wdata = win ? p1_wdata : 32'h0;
        in_range  = ({1'b0, sel_addr} < DEPTH_L);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        err_pend_d  = err_pend_q;
        mem_en_d    = mem_en_q;
        mem_wmask_d = mem_wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_done_d   = 1'b0;
        p1_done_d   = 1'b0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;

        case (state_q)
            IDLE, WAIT: begin
                state_d = IDLE;
                if (grant) begin
                    state_d     = ISSUE;
                    owner_d     = win;
                    last_d      = win;
                    err_pend_d  = !in_range;
                    mem_en_d    = in_range;
                    mem_wmask_d = in_range ? sel_wmask : 4'b0000;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                end
            end
            ISSUE: begin
                state_d     = WAIT;
                mem_en_d    = 1'b0;
                mem_wmask_d = 4'b0000;
                p0_done_d   = !owner_q;
                p1_done_d   = owner_q;
                p0_err_d    = !owner_q && err_pend_q;
                p1_err_d    = owner_q && err_pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            err_pend_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            err_pend_q  <= err_pend_d;
            mem_en_q    <= mem_en_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_done_q   <= p0_done_d;
            p1_done_q   <= p1_done_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
        end
    end

    // Read data passes straight through from the memory during the done cycle only.
    assign p0_rdata  = (p0_done_q && !err_pend_q) ? mem_rdata : 32'h0;
    assign p1_rdata  = (p1_done_q && !err_pend_q) ? mem_rdata : 32'h0;
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign mem_en    = mem_en_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural BRAM plus a transaction-level reference
// memory and round-robin model; directed steps followed by random traffic.
module tb_mem_arbiter;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 448;

    logic              clk;
    logic              resetn;
    logic              p0_req, p1_req;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [3:0]        p1_wmask;
    logic [31:0]       p1_wdata;
    logic              p0_done, p1_done, p0_err, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_en;
    logic [3:0]        mem_wmask;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int vectors;
    int miscompares;

    logic [31:0] bram [0:511];
    logic        bram_init;
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          last_m;

    mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_done(p0_done),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wmask(p1_wmask),
        .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_en(mem_en), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input int i);
        if (i == 5)  return 32'h0010_0073;
        if (i == 10) return 32'h1122_3344;
        return 32'hA5A5_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Behavioural single-port memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (bram_init !== 1'b1) begin
            for (int i = 0; i < 512; i++) bram[i] <= init_val(i);
            bram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_wmask == 4'b0000) mem_rdata <= bram[mem_addr];
            else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) bram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference effect of one served access; returns expected rdata/err.
    task automatic model_access(input bit port, input logic [ADDR_W-1:0] a,
                                input logic [3:0] wm, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
        int ai;
        ai = int'(a);
        er = (ai >= DEPTH);
        rd = 32'h0;
        if (!er) begin
            if (port == 1'b0 || wm == 4'b0000) rd = ref_mem[ai];
            else
                for (int b = 0; b < 4; b++)
                    if (wm[b]) ref_mem[ai][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    // Raise the selected requests together from IDLE and check the next 5 cycles.
    task automatic serve(input bit r0, input bit r1,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [3:0] wm, input logic [31:0] wd);
        bit first1, port;
        int t0, t1;
        logic [31:0] e0, e1;
        bit er0, er1, in_r;
        logic [ADDR_W-1:0] pa;
        first1 = (r0 && r1) ? (last_m == 1'b0) : r1;
        t0 = -1;
        t1 = -1;
        if (r0) t0 = (r1 && first1) ? 4 : 2;
        if (r1) t1 = (r0 && !first1) ? 4 : 2;
        e0 = 32'h0; e1 = 32'h0; er0 = 1'b0; er1 = 1'b0;
        if (first1) begin
            if (r1) model_access(1'b1, a1, wm, wd, e1, er1);
            if (r0) model_access(1'b0, a0, 4'b0000, 32'h0, e0, er0);
        end else begin
            if (r0) model_access(1'b0, a0, 4'b0000, 32'h0, e0, er0);
            if (r1) model_access(1'b1, a1, wm, wd, e1, er1);
        end
        if (r0 || r1) last_m = (r0 && r1) ? !first1 : r1;

        @(negedge clk);
        p0_req = r0; p0_addr = a0;
        p1_req = r1; p1_addr = a1; p1_wmask = wm; p1_wdata = wd;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("p0_done", {31'h0, p0_done}, {31'h0, i == t0});
            chk("p1_done", {31'h0, p1_done}, {31'h0, i == t1});
            if (i == t0) begin
                chk("p0_err", {31'h0, p0_err}, {31'h0, er0});
                chk("p0_rdata", p0_rdata, e0);
                p0_req = 1'b0;
            end else chk("p0_rdata_idle", p0_rdata, 32'h0);
            if (i == t1) begin
                chk("p1_err", {31'h0, p1_err}, {31'h0, er1});
                if (wm == 4'b0000 || er1) chk("p1_rdata", p1_rdata, e1);
                p1_req = 1'b0;
            end else chk("p1_rdata_idle", p1_rdata, 32'h0);
            if ((i == 1 && (r0 || r1)) || (i == 3 && r0 && r1)) begin
                port = (i == 1) ? first1 : !first1;
                pa   = port ? a1 : a0;
                in_r = (int'(pa) < DEPTH);
                chk("mem_en_issue", {31'h0, mem_en}, {31'h0, in_r});
                if (in_r) begin
                    chk("mem_addr", {23'h0, mem_addr}, {23'h0, pa});
                    chk("mem_wmask", {28'h0, mem_wmask}, port ? {28'h0, wm} : 32'h0);
                    if (port && wm != 4'b0000) chk("mem_wdata", mem_wdata, wd);
                end
            end else chk("mem_en_quiet", {31'h0, mem_en}, 32'h0);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom_range(DEPTH - 8, 511));
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        last_m = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_addr = '0; p1_wmask = 4'b0000; p1_wdata = 32'h0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_addr", {23'h0, mem_addr}, 32'h0);
        chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_dones", {30'h0, p0_done, p1_done}, 32'h0);
        chk("rst_errs", {30'h0, p0_err, p1_err}, 32'h0);
        resetn = 1'b1;

        serve(1'b1, 1'b0, 9'd5, 9'd0, 4'b0000, 32'h0);
        serve(1'b0, 1'b1, 9'd0, 9'd10, 4'b0011, 32'hAABB_CCDD);
        serve(1'b0, 1'b1, 9'd0, 9'd10, 4'b0000, 32'h0);
        chk("rmw_value", ref_mem[10], 32'h1122_CCDD);
        serve(1'b1, 1'b1, 9'd5, 9'd10, 4'b0000, 32'h0);
        serve(1'b1, 1'b1, 9'd11, 9'd12, 4'b1111, 32'hDEAD_BEEF);
        serve(1'b0, 1'b1, 9'd0, 9'd448, 4'b0000, 32'h0);
        serve(1'b0, 1'b1, 9'd0, 9'd500, 4'b1111, 32'h1234_5678);
        serve(1'b1, 1'b0, 9'd511, 9'd0, 4'b0000, 32'h0);
        serve(1'b1, 1'b0, 9'd447, 9'd0, 4'b0000, 32'h0);

        // Reset asserted while a p0 access sits in ISSUE.
        @(negedge clk);
        p0_req = 1'b1; p0_addr = 9'd7;
        @(negedge clk);
        chk("mid_issue_en", {31'h0, mem_en}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("async_mem_en", {31'h0, mem_en}, 32'h0);
        chk("async_mem_addr", {23'h0, mem_addr}, 32'h0);
        chk("async_dones", {30'h0, p0_done, p1_done}, 32'h0);
        p0_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        last_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {30'h0, p0_done, p1_done}, 32'h0);
        end
        serve(1'b1, 1'b1, 9'd5, 9'd7, 4'b0000, 32'h0);

        for (int n = 0; n < 60; n++) begin
            int mode;
            logic [3:0] wm;
            mode = $urandom_range(0, 2);
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            serve(mode != 1, mode != 0, rnd_addr(), rnd_addr(), wm, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
